// File: rtl/booth_mult_sched_if.sv
// Request, response and datapath-control bundle for booth_mult_sched.
// The slave modport is the scheduler's view; master is the environment's view.
interface booth_mult_sched_if #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH
);
    logic                    req0_valid;
    logic                    req0_ready;
    logic [INPUT_WIDTH-1:0]  req0_multiplicand;
    logic [INPUT_WIDTH-1:0]  req0_multiplier;

    logic                    req1_valid;
    logic                    req1_ready;
    logic [INPUT_WIDTH-1:0]  req1_multiplicand;
    logic [INPUT_WIDTH-1:0]  req1_multiplier;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [OUTPUT_WIDTH-1:0] resp_product;
    logic                    resp_id;
    logic                    busy;

    logic                    dp_load;
    logic                    dp_en;
    logic [INPUT_WIDTH-1:0]  dp_multiplicand;
    logic [INPUT_WIDTH-1:0]  dp_multiplier;
    logic [OUTPUT_WIDTH-1:0] dp_product;

    modport slave (
        input  req0_valid, req0_multiplicand, req0_multiplier,
        output req0_ready,
        input  req1_valid, req1_multiplicand, req1_multiplier,
        output req1_ready,
        output resp_valid, resp_product, resp_id, busy,
        input  resp_ready,
        output dp_load, dp_en, dp_multiplicand, dp_multiplier,
        input  dp_product
    );

    modport master (
        output req0_valid, req0_multiplicand, req0_multiplier,
        input  req0_ready,
        output req1_valid, req1_multiplicand, req1_multiplier,
        input  req1_ready,
        input  resp_valid, resp_product, resp_id, busy,
        output resp_ready,
        input  dp_load, dp_en, dp_multiplicand, dp_multiplier,
        output dp_product
    );
endinterface

// File: rtl/booth_mult_sched.sv
// Two-port round-robin scheduler and sequencer for a radix-4 Booth multiplier
// datapath. One operation at a time: IDLE accepts, LOAD resets the datapath,
// RUN enables it for INPUT_WIDTH/2 cycles, CAPTURE moves the product into a
// one-entry response buffer (stalling while that buffer is still occupied).
module booth_mult_sched #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    booth_mult_sched_if.slave bus
);
    localparam int N_ITER = INPUT_WIDTH / 2;
    localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_rr_ptr;
    logic                    r_id;
    logic [INPUT_WIDTH-1:0]  r_mcand;
    logic [INPUT_WIDTH-1:0]  r_mplier;
    logic                    r_resp_valid;
    logic [OUTPUT_WIDTH-1:0] r_resp_product;
    logic                    r_resp_id;
    logic                    r_dp_load;
    logic                    r_dp_en;
    logic                    r_busy;

    logic                    w_grant;
    logic                    w_any_valid;
    logic                    w_handshake;
    logic                    w_capture;
    logic                    w_resp_valid_nxt;

    // Requester that IDLE would accept: a lone valid wins, a tie goes to the rr pointer.
    always_comb begin
        w_grant = r_rr_ptr;
        if (bus.req0_valid && !bus.req1_valid) begin
            w_grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = r_rr_ptr;
        end
    end

    assign w_any_valid = bus.req0_valid | bus.req1_valid;
    assign w_handshake = (r_state == ST_IDLE) && w_any_valid;
    // Buffer is free if empty or being drained this cycle; refill then wins over the drain.
    assign w_capture   = (r_state == ST_CAPTURE) && (!r_resp_valid || bus.resp_ready);
    assign w_resp_valid_nxt = w_capture || (r_resp_valid && !bus.resp_ready);

    // Ready is combinational from state and valids so acceptance happens in the same cycle.
    assign bus.req0_ready = w_handshake && !w_grant;
    assign bus.req1_ready = w_handshake && w_grant;

    // Next-state decode of the operation sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_CAPTURE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_CAPTURE: begin
                if (w_capture) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_CAPTURE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dp_load <= 1'b0;
            r_dp_en   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_dp_load <= (w_next_state == ST_LOAD);
            r_dp_en   <= (w_next_state == ST_RUN);
            r_busy    <= (w_next_state != ST_IDLE) || w_resp_valid_nxt;
        end
    end

    // Iteration counter: cleared in LOAD, counts each RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_LOAD) begin
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // On acceptance latch operands and owner, and hand priority to the other requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_id     <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else if (w_handshake) begin
            r_mcand  <= w_grant ? bus.req1_multiplicand : bus.req0_multiplicand;
            r_mplier <= w_grant ? bus.req1_multiplier   : bus.req0_multiplier;
            r_id     <= w_grant;
            r_rr_ptr <= !w_grant;
        end else begin
            r_mcand  <= r_mcand;
            r_mplier <= r_mplier;
            r_id     <= r_id;
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // One-entry response buffer; contents frozen while held under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid   <= 1'b0;
            r_resp_product <= '0;
            r_resp_id      <= 1'b0;
        end else if (w_capture) begin
            r_resp_valid   <= 1'b1;
            r_resp_product <= bus.dp_product;
            r_resp_id      <= r_id;
        end else if (r_resp_valid && bus.resp_ready) begin
            r_resp_valid   <= 1'b0;
            r_resp_product <= r_resp_product;
            r_resp_id      <= r_resp_id;
        end else begin
            r_resp_valid   <= r_resp_valid;
            r_resp_product <= r_resp_product;
            r_resp_id      <= r_resp_id;
        end
    end

    assign bus.dp_load         = r_dp_load;
    assign bus.dp_en           = r_dp_en;
    assign bus.dp_multiplicand = r_mcand;
    assign bus.dp_multiplier   = r_mplier;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_product    = r_resp_product;
    assign bus.resp_id         = r_resp_id;
    assign bus.busy            = r_busy;
endmodule

// File: tb/tb_booth_mult_sched.sv
// Self-checking bench for booth_mult_sched with a stand-in radix-4 Booth datapath.
module tb_booth_mult_sched;
    localparam int IW   = 6;
    localparam int OW   = 12;
    localparam int N_IT = IW / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   ptr   = 1'b0;

    typedef struct { logic [IW-1:0] a; logic [IW-1:0] b; } op_t;
    typedef struct { bit id; logic [IW-1:0] a; logic [IW-1:0] b; logic [OW-1:0] prod; } vec_t;

    op_t           q0[$];
    op_t           q1[$];
    logic [OW-1:0] e0[$];
    logic [OW-1:0] e1[$];
    bit            glog[$];
    logic [OW:0]   rlog[$];

    booth_mult_sched_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

    booth_mult_sched #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: one radix-4 Booth digit per enable; extra enables corrupt the result.
    function automatic logic [OW-1:0] booth_step(input logic [OW-1:0] acc, input logic [IW-1:0] mc,
                                                 input logic [IW-1:0] mp, input int i);
        logic [IW:0] ext;
        logic [2:0]  trip;
        int          d;
        int          m;
        int          term;
        if (i >= N_IT) return acc ^ {{(OW-1){1'b0}}, 1'b1};
        ext  = {mp, 1'b0};
        trip = ext[2*i+2 -: 3];
        case (trip)
            3'b001, 3'b010: d = 1;
            3'b011:         d = 2;
            3'b100:         d = -2;
            3'b101, 3'b110: d = -1;
            default:        d = 0;
        endcase
        m    = $signed(mc);
        term = (d * m) <<< (2 * i);
        return acc + OW'(term);
    endfunction

    logic [OW-1:0] dp_acc  = '0;
    int            dp_step = 0;
    always @(posedge clk) begin
        if (bus.dp_load) begin
            dp_acc  <= '0;
            dp_step <= 0;
        end else if (bus.dp_en) begin
            dp_acc  <= booth_step(dp_acc, bus.dp_multiplicand, bus.dp_multiplier, dp_step);
            dp_step <= dp_step + 1;
        end
    end
    assign bus.dp_product = dp_acc;

    // Reference product: plain signed multiplication truncated to the output width.
    function automatic logic [OW-1:0] exp_prod(input logic [IW-1:0] a, input logic [IW-1:0] b);
        int p;
        p = $signed(a) * $signed(b);
        return OW'(p);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_ready0"},  bus.req0_ready, 0);
        chk({tag, "_ready1"},  bus.req1_ready, 0);
        chk({tag, "_dp_load"}, bus.dp_load, 0);
        chk({tag, "_dp_en"},   bus.dp_en, 0);
        chk({tag, "_rvalid"},  bus.resp_valid, 0);
        chk({tag, "_rprod"},   bus.resp_product, 0);
        chk({tag, "_rid"},     bus.resp_id, 0);
        chk({tag, "_busy"},    bus.busy, 0);
        chk({tag, "_dp_mc"},   bus.dp_multiplicand, 0);
        chk({tag, "_dp_mp"},   bus.dp_multiplier, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b0;
        q0.delete(); q1.delete(); e0.delete(); e1.delete(); glog.delete(); rlog.delete();
        ptr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Present one operation and hold it until accepted; returns at the LOAD-cycle negedge.
    task automatic issue(input bit id, input logic [IW-1:0] a, input logic [IW-1:0] b);
        bit got = 1'b0;
        @(negedge clk);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_multiplicand = a; bus.req1_multiplier = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_multiplicand = a; bus.req0_multiplier = b;
        end
        for (int n = 0; n < 40 && !got; n++) begin
            #3;
            if ((id ? bus.req1_ready : bus.req0_ready) == 1'b1) got = 1'b1;
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("issue_accepted", got, 1);
    endtask

    task automatic wait_resp(output logic [OW-1:0] p, output bit id, output bit ok);
        ok = 1'b0; p = '0; id = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            #3;
            if (bus.resp_valid) begin
                p = bus.resp_product; id = bus.resp_id; ok = 1'b1;
            end
        end
    endtask

    // Drive both requester queues, score grants against the rr rule and results per requester.
    task automatic run_ops(input bit rnd, input int max_cyc);
        bit          act0 = 1'b0;
        bit          act1 = 1'b0;
        bit          hold = 1'b0;
        bit          g;
        logic [OW:0] held = '0;
        for (int n = 0; n < max_cyc; n++) begin
            if (q0.size() == 0 && q1.size() == 0 && e0.size() == 0 && e1.size() == 0) break;
            @(negedge clk);
            if (!act0 && q0.size() > 0) act0 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!act1 && q1.size() > 0) act1 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.req0_valid = act0;
            bus.req1_valid = act1;
            if (act0) begin bus.req0_multiplicand = q0[0].a; bus.req0_multiplier = q0[0].b; end
            if (act1) begin bus.req1_multiplicand = q1[0].a; bus.req1_multiplier = q1[0].b; end
            bus.resp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #3;
            chk("ready_overlap", bus.req0_ready && bus.req1_ready, 0);
            chk("ready_without_valid", (bus.req0_ready && !act0) || (bus.req1_ready && !act1), 0);
            if (hold) begin
                chk("resp_hold_valid", bus.resp_valid, 1);
                chk("resp_hold_data", {bus.resp_id, bus.resp_product}, held);
            end
            hold = bus.resp_valid && !bus.resp_ready;
            held = {bus.resp_id, bus.resp_product};
            if ((act0 && bus.req0_ready) || (act1 && bus.req1_ready)) begin
                g = act1 && bus.req1_ready;
                if (act0 && act1) chk("rr_grant", g, ptr);
                ptr = !g;
                glog.push_back(g);
                if (g) begin
                    e1.push_back(exp_prod(q1[0].a, q1[0].b)); void'(q1.pop_front()); act1 = 1'b0;
                end else begin
                    e0.push_back(exp_prod(q0[0].a, q0[0].b)); void'(q0.pop_front()); act0 = 1'b0;
                end
            end
            if (bus.resp_valid && bus.resp_ready) begin
                rlog.push_back({bus.resp_id, bus.resp_product});
                if (bus.resp_id ? (e1.size() == 0) : (e0.size() == 0)) begin
                    chk("resp_spurious", 1, 0);
                end else if (bus.resp_id) begin
                    chk("resp1_product", bus.resp_product, e1.pop_front());
                end else begin
                    chk("resp0_product", bus.resp_product, e0.pop_front());
                end
            end
        end
        chk("ops_drained", q0.size() + q1.size() + e0.size() + e1.size(), 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          tbl[8];
        logic [OW-1:0] p;
        bit            id;
        bit            ok;
        int            cnt;
        op_t           o;

        tbl[0] = '{1'b0, 6'd5,          6'd3,          12'h00F};
        tbl[1] = '{1'b0, 6'(-7),        6'd6,          12'hFD6};
        tbl[2] = '{1'b1, 6'(-31),       6'(-32),       12'h3E0};
        tbl[3] = '{1'b1, 6'd31,         6'(-32),       12'hC20};
        tbl[4] = '{1'b1, 6'd4,          6'd4,          12'h010};
        tbl[5] = '{1'b0, 6'(-32),       6'(-32),       12'h400};
        tbl[6] = '{1'b0, 6'd31,         6'd31,         12'h3C1};
        tbl[7] = '{1'b1, 6'(-32),       6'd31,         12'hC20};

        bus.req0_valid = 1'b0; bus.req0_multiplicand = '0; bus.req0_multiplier = '0;
        bus.req1_valid = 1'b0; bus.req1_multiplicand = '0; bus.req1_multiplier = '0;
        bus.resp_ready = 1'b0;

        // Reset state, then latency of a single 5x3 operation.
        repeat (2) @(negedge clk);
        #3;
        chk_rst("reset");
        @(negedge clk);
        rst = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_multiplicand = 6'd5; bus.req0_multiplier = 6'd3;
        #3;
        chk("lat_ready0_T", bus.req0_ready, 1);
        chk("lat_ready1_T", bus.req1_ready, 0);
        chk("lat_dp_load_T", bus.dp_load, 0);
        for (int k = 1; k <= N_IT + 4; k++) begin
            @(negedge clk);
            if (k == 1) bus.req0_valid = 1'b0;
            #3;
            chk("lat_dp_load", bus.dp_load, (k == 1));
            chk("lat_dp_en", bus.dp_en, (k >= 2 && k <= N_IT + 1));
            chk("lat_resp_valid", bus.resp_valid, (k == N_IT + 3));
            chk("lat_busy", bus.busy, (k <= N_IT + 3));
            if (k == N_IT + 3) begin
                chk("lat_product", bus.resp_product, 12'h00F);
                chk("lat_id", bus.resp_id, 0);
            end
        end

        // Table of single operations through either requester.
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].id, tbl[i].a, tbl[i].b);
            wait_resp(p, id, ok);
            chk("tbl_resp_seen", ok, 1);
            chk("tbl_product", p, tbl[i].prod);
            chk("tbl_id", id, tbl[i].id);
        end

        // Both valid right after reset: requester 0 first, then requester 1.
        do_reset();
        q0.push_back('{6'(-7), 6'd6});
        q1.push_back('{6'(-31), 6'(-32)});
        run_ops(1'b0, 200);
        chk("pair_ngrant", glog.size(), 2);
        chk("pair_nresp", rlog.size(), 2);
        if (glog.size() == 2 && rlog.size() == 2) begin
            chk("pair_grant0", glog[0], 0);
            chk("pair_grant1", glog[1], 1);
            chk("pair_resp0", rlog[0], {1'b0, 12'hFD6});
            chk("pair_resp1", rlog[1], {1'b1, 12'h3E0});
        end

        // Both continuously valid: grants alternate.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{6'd31, 6'(-32)});
            q1.push_back('{6'd31, 6'(-32)});
        end
        run_ops(1'b0, 200);
        chk("alt_ngrant", glog.size(), 4);
        chk("alt_nresp", rlog.size(), 4);
        if (glog.size() == 4 && rlog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("alt_grant", glog[i], i % 2);
                chk("alt_resp", rlog[i], {1'(i % 2), 12'hC20});
            end
        end

        // Backpressure: first result held, second stalls in CAPTURE, one-cycle drain refills.
        do_reset();
        issue(1'b0, 6'd5, 6'd3);
        issue(1'b1, 6'(-7), 6'd6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            chk("bp_hold_valid", bus.resp_valid, 1);
            chk("bp_hold_data", {bus.resp_id, bus.resp_product}, {1'b0, 12'h00F});
        end
        chk("bp_stall_dp_en", bus.dp_en, 0);
        chk("bp_stall_dp_load", bus.dp_load, 0);
        chk("bp_stall_busy", bus.busy, 1);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        #3;
        chk("bp_drain_data", {bus.resp_id, bus.resp_product}, {1'b0, 12'h00F});
        @(negedge clk);
        bus.resp_ready = 1'b0;
        #3;
        chk("bp_refill_valid", bus.resp_valid, 1);
        chk("bp_refill_data", {bus.resp_id, bus.resp_product}, {1'b1, 12'hFD6});
        chk("bp_refill_dp_en", bus.dp_en, 0);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        #3;
        chk("bp_empty_valid", bus.resp_valid, 0);
        chk("bp_empty_busy", bus.busy, 0);

        // Reset during the second RUN cycle abandons the operation.
        do_reset();
        bus.resp_ready = 1'b1;
        issue(1'b0, 6'd5, 6'd3);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("midrst_in_run", bus.dp_en, 1);
        rst = 1'b0;
        #1;
        chk_rst("midrst");
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1, 6'd4, 6'd4);
        wait_resp(p, id, ok);
        chk("midrst_resp_seen", ok, 1);
        chk("midrst_product", p, 12'h010);
        chk("midrst_id", id, 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #3;
            if (bus.resp_valid) cnt++;
        end
        chk("midrst_no_extra", cnt, 0);

        // Requester 1 drops valid while busy: ignored, and priority still comes from req0's grant.
        do_reset();
        bus.resp_ready = 1'b1;
        issue(1'b0, 6'd5, 6'd3);
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_multiplicand = 6'd1; bus.req1_multiplier = 6'd1;
        #3;
        chk("drop_ready1_busy", bus.req1_ready, 0);
        @(negedge clk);
        #3;
        chk("drop_ready1_busy2", bus.req1_ready, 0);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_resp(p, id, ok);
        chk("drop_resp_seen", ok, 1);
        chk("drop_resp_data", {id, p}, {1'b0, 12'h00F});
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #3;
            if (bus.resp_valid) cnt++;
        end
        chk("drop_no_resp", cnt, 0);
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_multiplicand = 6'd2; bus.req0_multiplier = 6'd2;
        bus.req1_valid = 1'b1; bus.req1_multiplicand = 6'd3; bus.req1_multiplier = 6'd3;
        #3;
        chk("drop_rr_ready1", bus.req1_ready, 1);
        chk("drop_rr_ready0", bus.req0_ready, 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_resp(p, id, ok);
        chk("drop_rr_resp", {id, p}, {1'b1, 12'h009});

        // Randomized traffic with random backpressure against the reference model.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            o.a = IW'($urandom_range(0, 63)); o.b = IW'($urandom_range(0, 63));
            q0.push_back(o);
            o.a = IW'($urandom_range(0, 63)); o.b = IW'($urandom_range(0, 63));
            q1.push_back(o);
        end
        run_ops(1'b1, 3000);
        chk("rand_ngrant", glog.size(), 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
